// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: op encodings and return-stack count width helper for pc_sequencer.
package pc_seq_pkg;
  typedef enum logic [2:0] {
    OP_NEXT   = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4,
    OP_HOLD   = 3'd5
  } op_e;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/pc_ret_stack.sv
// pc_ret_stack: LIFO return-address stack; write pointer is count, no overflow/underflow policy.
// Ports: clk, rst (async, active-high), push, pop, wdata -> rdata (top entry), count, full, empty.
module pc_ret_stack
  import pc_seq_pkg::*;
#(
  parameter int W     = 16,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [W-1:0]               wdata,
  output logic [W-1:0]               rdata,
  output logic [cnt_w(DEPTH)-1:0]    count,
  output logic                       full,
  output logic                       empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] top;
  assign top   = PW'(count - 1'b1);
  assign rdata = mem[top];
  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[count[PW-1:0]] <= wdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= '0;
    else if (push) count <= count + 1'b1;
    else if (pop) count <= count - 1'b1;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-stage PC sequencer with NEXT/JUMP/BRANCH/CALL/RET and a return-address stack.
// Ports: clk, rst (async, active-high), pc_enable, op, cond, bus, offset -> pc, ras_count,
// ras_full, ras_empty, err (sticky overflow/underflow). With PC_IRQ_EN defined, irq_req/irq_ack
// add an interrupt entry at IRQ_VEC that pushes the interrupted pc.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int                 ADDR_W    = 16,
  parameter int                 RAS_DEPTH = 8,
  parameter logic [ADDR_W-1:0]  RESET_VEC = '0,
  parameter logic [ADDR_W-1:0]  IRQ_VEC   = ADDR_W'(16'h0004)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pc_enable,
  input  logic [2:0]                    op,
  input  logic                          cond,
  input  logic [ADDR_W-1:0]             bus,
  input  logic [ADDR_W-1:0]             offset,
  output logic [ADDR_W-1:0]             pc,
  output logic [cnt_w(RAS_DEPTH)-1:0]   ras_count,
  output logic                          ras_full,
  output logic                          ras_empty,
`ifdef PC_IRQ_EN
  input  logic                          irq_req,
  output logic                          irq_ack,
`endif
  output logic                          err
);
  logic [ADDR_W-1:0] inc, nxt, wdata, rdata;
  logic              push, pop, err_set, take;
  assign inc = pc + 1'b1;
`ifdef PC_IRQ_EN
  logic in_isr;
  assign take = irq_req & ~in_isr & ~ras_full;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      in_isr  <= 1'b0;
      irq_ack <= 1'b0;
    end else begin
      irq_ack <= pc_enable & take;
      if (pc_enable) in_isr <= take | (in_isr & (op != OP_RET));
    end
`else
  assign take = 1'b0;
`endif
  always_comb begin
    push    = 1'b0;
    pop     = 1'b0;
    err_set = 1'b0;
    wdata   = inc;
    nxt     = pc;
    if (take) begin
      push  = 1'b1;
      wdata = pc;
      nxt   = IRQ_VEC;
    end else
      case (op)
        OP_NEXT:   nxt = inc;
        OP_JUMP:   nxt = bus;
        OP_BRANCH: nxt = cond ? pc + offset : inc;
        OP_CALL: begin
          push    = ~ras_full;
          err_set = ras_full;
          nxt     = bus;
        end
        OP_RET: begin
          pop     = ~ras_empty;
          err_set = ras_empty;
          nxt     = ras_empty ? inc : rdata;
        end
        default: nxt = pc;
      endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc  <= RESET_VEC;
      err <= 1'b0;
    end else if (pc_enable) begin
      pc  <= nxt;
      err <= err | err_set;
    end
  pc_ret_stack #(.W(ADDR_W), .DEPTH(RAS_DEPTH)) u_ras (
    .clk(clk),
    .rst(rst),
    .push(push & pc_enable),
    .pop(pop & pc_enable),
    .wdata(wdata),
    .rdata(rdata),
    .count(ras_count),
    .full(ras_full),
    .empty(ras_empty)
  );
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_enable = 1'b0;
  logic [2:0]  op = 3'd0;
  logic        cond = 1'b0;
  logic [15:0] bus = '0;
  logic [15:0] offset = '0;
  logic [15:0] pc;
  logic [3:0]  ras_count;
  logic        ras_full, ras_empty, err;
  int          vecs = 0;
  int          errs = 0;
`ifdef PC_IRQ_EN
  logic        irq_req = 1'b0;
  logic        irq_ack;
`endif
  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_enable(pc_enable), .op(op), .cond(cond),
    .bus(bus), .offset(offset), .pc(pc), .ras_count(ras_count),
    .ras_full(ras_full), .ras_empty(ras_empty),
`ifdef PC_IRQ_EN
    .irq_req(irq_req), .irq_ack(irq_ack),
`endif
    .err(err)
  );
  always #5 clk = ~clk;
  task automatic step(input logic [2:0] o, input logic [15:0] b);
    pc_enable = 1'b1;
    op = o;
    bus = b;
    @(posedge clk);
    #1;
  endtask
  task automatic chk_pc(input string name, input logic [15:0] exp);
    vecs++;
    if (pc !== exp) begin
      errs++;
      $display("FAIL %s: pc=%h expected %h", name, pc, exp);
    end
  endtask
  task automatic chk_st(input string name, input logic [3:0] cnt, input logic e);
    vecs++;
    if (ras_count !== cnt || err !== e || ras_full !== (cnt == 4'd8) || ras_empty !== (cnt == 4'd0)) begin
      errs++;
      $display("FAIL %s: count=%0d full=%b empty=%b err=%b expected count=%0d err=%b",
               name, ras_count, ras_full, ras_empty, err, cnt, e);
    end
  endtask
  task automatic test_reset;
    #12 rst = 1'b0;
    chk_pc("reset_pc", 16'h0000);
    chk_st("reset_stat", 4'd0, 1'b0);
    step(3'd4, 16'h0000);
    chk_pc("ret_empty_pc", 16'h0001);
    chk_st("ret_empty_err", 4'd0, 1'b1);
    step(3'd3, 16'h0123);
    chk_pc("pre_rst_pc", 16'h0123);
    chk_st("pre_rst_stat", 4'd1, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk_pc("async_rst_pc", 16'h0000);
    chk_st("async_rst_stat", 4'd0, 1'b0);
    #2 rst = 1'b0;
  endtask
  task automatic test_next;
    step(3'd0, 16'h0); chk_pc("next1", 16'h0001);
    step(3'd0, 16'h0); chk_pc("next2", 16'h0002);
    step(3'd0, 16'h0); chk_pc("next3", 16'h0003);
    pc_enable = 1'b0;
    @(posedge clk); #1; chk_pc("hold_en1", 16'h0003);
    op = 3'd1; bus = 16'h7777;
    @(posedge clk); #1; chk_pc("hold_en2", 16'h0003);
    step(3'd1, 16'hFFFF); chk_pc("jump_ffff", 16'hFFFF);
    step(3'd0, 16'h0); chk_pc("next_wrap", 16'h0000);
    chk_st("wrap_noerr", 4'd0, 1'b0);
  endtask
  task automatic test_branch;
    step(3'd1, 16'h0010);
    cond = 1'b1; offset = 16'hFFFC;
    step(3'd2, 16'h0); chk_pc("branch_taken_neg", 16'h000C);
    step(3'd1, 16'h0010);
    cond = 1'b0;
    step(3'd2, 16'h0); chk_pc("branch_not_taken", 16'h0011);
    cond = 1'b1; offset = 16'h0000;
    step(3'd2, 16'h0); chk_pc("branch_selfloop", 16'h0011);
    offset = 16'h0100;
    step(3'd2, 16'h0); chk_pc("branch_taken_pos", 16'h0111);
    step(3'd5, 16'h0); chk_pc("hold5", 16'h0111);
    step(3'd7, 16'h9999); chk_pc("hold7", 16'h0111);
    chk_st("hold_stat", 4'd0, 1'b0);
    cond = 1'b0;
  endtask
  task automatic test_call_ret;
    step(3'd1, 16'h0050);
    step(3'd3, 16'h0200); chk_pc("call_pc", 16'h0200);
    chk_st("call_stat", 4'd1, 1'b0);
    step(3'd4, 16'h0); chk_pc("ret_pc", 16'h0051);
    chk_st("ret_stat", 4'd0, 1'b0);
  endtask
  task automatic test_overflow;
    step(3'd1, 16'h0000);
    for (int k = 1; k <= 9; k++) begin
      step(3'd3, 16'(k) << 8);
      chk_pc("ovf_call_pc", 16'(k) << 8);
      chk_st("ovf_call_stat", k > 8 ? 4'd8 : 4'(k), k > 8);
    end
    for (int j = 1; j <= 8; j++) begin
      step(3'd4, 16'h0);
      chk_pc("unwind_pc", (16'(8 - j) << 8) + 16'h0001);
      chk_st("unwind_stat", 4'(8 - j), 1'b1);
    end
    step(3'd4, 16'h0); chk_pc("udf_pc", 16'h0002);
    chk_st("udf_stat", 4'd0, 1'b1);
  endtask
`ifdef PC_IRQ_EN
  task automatic test_irq;
    step(3'd1, 16'h0030);
    irq_req = 1'b1;
    step(3'd1, 16'h0999); chk_pc("irq_entry", 16'h0004);
    vecs++;
    if (irq_ack !== 1'b1) begin errs++; $display("FAIL irq_ack_pulse: %b expected 1", irq_ack); end
    chk_st("irq_stat", 4'd1, 1'b1);
    step(3'd0, 16'h0); chk_pc("irq_ignored", 16'h0005);
    vecs++;
    if (irq_ack !== 1'b0) begin errs++; $display("FAIL irq_ack_drop: %b expected 0", irq_ack); end
    irq_req = 1'b0;
    step(3'd4, 16'h0); chk_pc("irq_ret", 16'h0030);
    chk_st("irq_ret_stat", 4'd0, 1'b1);
  endtask
`endif
  initial begin
    test_reset;
    test_next;
    test_branch;
    test_call_ret;
    test_overflow;
`ifdef PC_IRQ_EN
    test_irq;
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the CPU fetch stage.
- Each enabled cycle it selects the next PC from one of four sources: sequential increment, absolute jump from bus, PC-relative branch, or return address.
- Holds an internal return-address stack (RAS) for CALL/RET.
- Reports stack status and a sticky error flag to the control unit.

Parameters:
ADDR_W, 16, width of PC, bus and offset.
RAS_DEPTH, 8, return-stack entries (power of two, >=2).
RESET_VEC, 0, PC value loaded on reset.
IRQ_VEC, 16'h0004, interrupt entry address (used only with PC_IRQ_EN).

Ports:
clk  in  1  clock, rising edge.
rst  in  1  asynchronous, active-high reset.
pc_enable  in  1  advance/update PC this cycle; low = hold everything.
op  in  3  operation: 0 NEXT, 1 JUMP, 2 BRANCH, 3 CALL, 4 RET, 5-7 HOLD.
cond  in  1  branch condition, used by BRANCH only.
bus  in  ADDR_W  absolute target for JUMP/CALL.
offset  in  ADDR_W  two's-complement displacement for BRANCH.
pc  out  ADDR_W  current program counter (registered).
ras_count  out  $clog2(RAS_DEPTH)+1  valid stack entries.
ras_full  out  1  ras_count == RAS_DEPTH.
ras_empty  out  1  ras_count == 0.
err  out  1  sticky: overflow or underflow occurred.
irq_req  in  1  interrupt request, level (PC_IRQ_EN only).
irq_ack  out  1  one-cycle pulse on interrupt entry (PC_IRQ_EN only).

Behaviour:
- Reset (async, any time, including mid-operation):
  - pc=RESET_VEC, ras_count=0, err=0, irq_ack=0.
  - Stack contents are don't-care.
- All updates occur on posedge clk when pc_enable=1. With pc_enable=0, all state holds and op is ignored.
- Latency: pc reflects the selected source one cycle after the enabled edge. Outputs are all registered except ras_full and ras_empty, which decode ras_count.
- Arithmetic is modulo 2^ADDR_W; wrap-around is silent and not an error. Example: pc=FFFF, NEXT -> 0000.
- NEXT: pc <= pc+1.
- JUMP: pc <= bus.
- BRANCH:
  - cond=1: pc <= pc+offset. offset is signed; offset=0 produces a self-loop.
  - cond=0: pc <= pc+1.
- CALL:
  - Push pc+1 (wrapped), then pc <= bus.
  - If ras_full: jump still occurs, push is dropped, err<=1, ras_count unchanged.
- RET:
  - Pop the top entry to pc.
  - If ras_empty: pc <= pc+1, err<=1, ras_count stays 0.
- HOLD (5-7): pc unchanged; no stack activity.
- The RAS is a LIFO with write pointer = ras_count. Only one push or pop occurs per cycle.
- err clears only on reset.

Optional Feature:
Macro PC_IRQ_EN.
- Defined:
  - irq_req sampled on enabled edges, with priority over op.
  - When taken: push current pc (the interrupted instruction re-executes after RET), pc <= IRQ_VEC, irq_ack=1 for that cycle.
  - Taken only if not ras_full; if ras_full, op executes normally and the IRQ remains pending.
  - No further IRQ is accepted until a RET executes (internal in_isr flag, cleared by RET or reset).
- Undefined: irq_req/irq_ack ports are absent; behaviour is exactly as above.

Decomposition:
- Package pc_seq_pkg:
  - op encodings (OP_NEXT..OP_RET, OP_HOLD).
  - Function computing the ras_count width.
- Sub-module pc_ret_stack (parametrised LIFO):
  - Inputs: push, pop, wdata.
  - Outputs: rdata, count, full, empty.
  - No overflow/underflow policy inside; pc_sequencer owns the error handling.

Test Plan:
- Reset mid-run: pc=0x0123, assert rst between edges -> pc=RESET_VEC immediately, ras_count=0, err=0.
- NEXT×3 from 0, then pc_enable=0 for 2 cycles -> pc 1,2,3,3,3; NEXT at FFFF -> 0000, err=0.
- BRANCH at pc=0x0010: offset=0xFFFC, cond=1 -> 0x000C; cond=0 -> 0x0011.
- CALL bus=0x0200 at pc=0x0050 -> pc=0x0200, ras_count=1; RET -> pc=0x0051, ras_count=0.
- Overflow/underflow (RAS_DEPTH=8):
  - 9 nested CALLs -> 9th jumps, ras_count=8, err=1.
  - 8 RETs unwind correctly.
  - A further RET -> pc+1, err stays 1.
- PC_IRQ_EN: irq_req with op=JUMP at pc=0x0030 -> pc=IRQ_VEC, irq_ack pulse; second irq_req ignored; RET -> pc=0x0030.
